blackbox_queue: RTL and testbench

- Ready/valid FIFO implemented as a Verilog black box. It sits directly downstream of the single-cycle arithmetic black boxes (adder/subtractor class, 16-bit) and buffers their results for the Chisel consumer.
- Gives the black-box test suite a stateful, back-pressured stage with a parameterised width and depth, exercised through clock/reset binding and a handshake.
- Mirrors Chisel Queue semantics so the same test can swap it against the native Queue.

---
 rtl/blackbox_queue.sv | 93 +++++++++
 tb/tb_blackbox_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/blackbox_queue.sv
// blackbox_queue: ready/valid FIFO buffering 16-bit arithmetic results for a Chisel consumer.
// Ports: clock, reset (sync, active-high), enq_valid/enq_ready/enq_bits, deq_valid/deq_ready/deq_bits, count.
// Optional build macro BLACKBOX_QUEUE_FLOW_EN: an empty queue passes enq_bits straight to deq_bits.
// Default build (macro undefined): minimum latency is one cycle and there is no flow-through.
// Parameters: WIDTH payload bits (>=1), DEPTH entries (>=1, any value; pointers wrap by compare).

module blackbox_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [WIDTH-1:0]             enq_bits,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [WIDTH-1:0]             deq_bits,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    logic empty;
    logic full;
    logic bypass;
    logic enq_fire;
    logic deq_fire;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign enq_ready = !full;

`ifdef BLACKBOX_QUEUE_FLOW_EN
    // Empty queue: the producer word is presented immediately and, when
    // taken in the same cycle, never touches storage.
    assign deq_valid = !empty || enq_valid;
    assign deq_bits  = empty ? enq_bits : mem[head];
    assign bypass    = empty && enq_valid && deq_ready;
`else
    assign deq_valid = !empty;
    assign deq_bits  = mem[head];
    assign bypass    = 1'b0;
`endif

    // Storage-side handshakes; a bypassed word moves neither pointer.
    assign enq_fire = enq_valid && enq_ready && !bypass;
    assign deq_fire = deq_valid && deq_ready && !empty;

    // Array contents are left alone on reset; only the bookkeeping clears.
    always_ff @(posedge clock) begin
        if (!reset && enq_fire) begin
            mem[tail] <= enq_bits;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= next_ptr(tail);
            end
            if (deq_fire) begin
                head <= next_ptr(head);
            end
            unique case ({enq_fire, deq_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_blackbox_queue.sv
// tb_blackbox_queue: vector table, directed corner sequences and random traffic
// checked against a queue-based reference model for blackbox_queue (default build).

module tb_blackbox_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enq_valid = 1'b0;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits = '0;
    logic             deq_valid;
    logic             deq_ready = 1'b0;
    logic [WIDTH-1:0] deq_bits;
    logic [CW-1:0]    count;

    int n_total = 0;
    int n_pass  = 0;

    blackbox_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .count     (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             rst;
        logic             ev;
        logic [WIDTH-1:0] eb;
        logic             dr;
        logic             x_er;
        logic             x_dv;
        int               x_cnt;
        logic             chk_bits;
        logic [WIDTH-1:0] x_bits;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic ev, input int eb,
                                input logic dr, input logic er, input logic dv,
                                input int cnt, input logic cb, input int bits);
        vec_t v;
        v.rst = rst; v.ev = ev; v.eb = WIDTH'(eb); v.dr = dr;
        v.x_er = er; v.x_dv = dv; v.x_cnt = cnt;
        v.chk_bits = cb; v.x_bits = WIDTH'(bits);
        return v;
    endfunction

    // Drive, clock, then check post-edge state.
    task automatic cyc(input logic rst, input logic ev, input logic [WIDTH-1:0] eb,
                       input logic dr);
        reset = rst; enq_valid = ev; enq_bits = eb; deq_ready = dr;
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input logic er, input logic dv,
                               input int cnt, input logic cb, input int bits);
        chk({tag, "_enq_ready"}, int'(enq_ready), int'(er));
        chk({tag, "_deq_valid"}, int'(deq_valid), int'(dv));
        chk({tag, "_count"}, int'(count), cnt);
        if (cb) begin
            chk({tag, "_deq_bits"}, int'(deq_bits), bits);
        end
    endtask

    int q[$];

    task automatic model_cycle(input logic rst, input logic ev, input logic [WIDTH-1:0] eb,
                               input logic dr, input string tag);
        logic m_er;
        logic m_dv;
        m_er = (q.size() != DEPTH);
        m_dv = (q.size() != 0);
        reset = rst; enq_valid = ev; enq_bits = eb; deq_ready = dr;
        #1;
        check_state(tag, m_er, m_dv, q.size(), m_dv, m_dv ? q[0] : 0);
        @(posedge clock);
        if (rst) begin
            q.delete();
        end else begin
            if (m_dv && dr) void'(q.pop_front());
            if (m_er && ev) q.push_back(int'(eb));
        end
        #1;
    endtask

    initial begin
        // Reset, idle, fill past full, drain.
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0001, 0, 1, 1, 1, 1, 16'h0001));
        vecs.push_back(mk(0, 1, 16'h0002, 0, 1, 1, 2, 1, 16'h0001));
        vecs.push_back(mk(0, 1, 16'h0003, 0, 1, 1, 3, 1, 16'h0001));
        vecs.push_back(mk(0, 1, 16'h0004, 0, 0, 1, 4, 1, 16'h0001));
        vecs.push_back(mk(0, 1, 16'h0005, 0, 0, 1, 4, 1, 16'h0001));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3, 1, 16'h0002));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2, 1, 16'h0003));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 16'h0004));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        // Full with enq and deq both requested: only deq fires.
        vecs.push_back(mk(0, 1, 16'h0021, 0, 1, 1, 1, 1, 16'h0021));
        vecs.push_back(mk(0, 1, 16'h0022, 0, 1, 1, 2, 1, 16'h0021));
        vecs.push_back(mk(0, 1, 16'h0023, 0, 1, 1, 3, 1, 16'h0021));
        vecs.push_back(mk(0, 1, 16'h0024, 0, 0, 1, 4, 1, 16'h0021));
        vecs.push_back(mk(0, 1, 16'h0025, 1, 1, 1, 3, 1, 16'h0022));
        vecs.push_back(mk(0, 1, 16'h0025, 0, 0, 1, 4, 1, 16'h0022));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 3, 1, 16'h0023));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 2, 1, 16'h0024));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 1, 16'h0025));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
        // Reset mid-burst with a handshake presented; then no stale data.
        vecs.push_back(mk(0, 1, 16'h0031, 0, 1, 1, 1, 1, 16'h0031));
        vecs.push_back(mk(0, 1, 16'h0032, 0, 1, 1, 2, 1, 16'h0031));
        vecs.push_back(mk(0, 1, 16'h0033, 0, 1, 1, 3, 1, 16'h0031));
        vecs.push_back(mk(1, 1, 16'h0034, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 16'hBEEF, 0, 1, 1, 1, 1, 16'hBEEF));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].ev, vecs[i].eb, vecs[i].dr);
            check_state($sformatf("vec%0d", i), vecs[i].x_er, vecs[i].x_dv,
                        vecs[i].x_cnt, vecs[i].chk_bits, int'(vecs[i].x_bits));
        end

        // Streaming: one word per cycle, occupancy pinned at 1.
        for (int k = 0; k < 16; k++) begin
            cyc(0, 1, WIDTH'(16'h0010 + k), 1);
            check_state($sformatf("stream%0d", k), 1, 1, 1, 1, 16'h0010 + k);
        end
        cyc(0, 0, '0, 1);
        check_state("stream_end", 1, 0, 0, 0, 0);

        // Wrap: 10 rounds of 3 in, 3 out, so pointers cross DEPTH-1 often.
        q.delete();
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < 3; j++)
                model_cycle(0, 1, WIDTH'(16'h0100 + r * 3 + j), 0, $sformatf("wrap_in%0d_%0d", r, j));
            for (int j = 0; j < 3; j++)
                model_cycle(0, 0, '0, 1, $sformatf("wrap_out%0d_%0d", r, j));
        end

        // Random traffic against the queue model, occasional reset.
        for (int c = 0; c < 600; c++) begin
            model_cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
                        WIDTH'($urandom), ($urandom_range(0, 99) < 50),
                        $sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
